// File: rtl/stopwatch_counter.sv
// MM:SS stopwatch core: four BCD digits advanced by a one-second tick,
// with pause and per-digit saturating adjustment while paused.
module stopwatch_counter #(
    parameter logic [26:0] TICK_VALUE = 27'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [26:0] out1,
    input  logic        paused,
    input  logic [2:0]  adj_sel,
    input  logic [4:0]  adj_val,
    output logic [4:0]  min_l,
    output logic [4:0]  min_r,
    output logic [4:0]  sec_l,
    output logic [4:0]  sec_r
);

    typedef enum logic [2:0] {
        ADJ_NONE  = 3'd0,
        ADJ_MIN_L = 3'd1,
        ADJ_MIN_R = 3'd2,
        ADJ_SEC_L = 3'd3,
        ADJ_SEC_R = 3'd4
    } adj_sel_t;

    logic [3:0] min_l_q, min_r_q, sec_l_q, sec_r_q;
    logic       tick;

    assign tick = (out1 == TICK_VALUE);

    // Clamp a requested digit value to the digit's legal maximum.
    function automatic logic [3:0] sat(input logic [4:0] v, input logic [3:0] lim);
        return (v > {1'b0, lim}) ? lim : v[3:0];
    endfunction

    // NOTE: all digit state uses non-blocking assignments so the carry chain
    // reads the pre-edge values of every digit, like real flip-flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            min_l_q <= 4'd0;
            min_r_q <= 4'd0;
            sec_l_q <= 4'd0;
            sec_r_q <= 4'd0;
        end else if (paused) begin
            // Paused: ticks are ignored; only the selected digit may change.
            case (adj_sel)
                ADJ_MIN_L: min_l_q <= sat(adj_val, 4'd9);
                ADJ_MIN_R: min_r_q <= sat(adj_val, 4'd9);
                ADJ_SEC_L: sec_l_q <= sat(adj_val, 4'd5);
                ADJ_SEC_R: sec_r_q <= sat(adj_val, 4'd9);
                default: ;
            endcase
        end else if (tick) begin
            if (sec_r_q == 4'd9) begin
                sec_r_q <= 4'd0;
                if (sec_l_q == 4'd5) begin
                    sec_l_q <= 4'd0;
                    if (min_r_q == 4'd9) begin
                        min_r_q <= 4'd0;
                        min_l_q <= (min_l_q == 4'd9) ? 4'd0 : min_l_q + 4'd1;
                    end else begin
                        min_r_q <= min_r_q + 4'd1;
                    end
                end else begin
                    sec_l_q <= sec_l_q + 4'd1;
                end
            end else begin
                sec_r_q <= sec_r_q + 4'd1;
            end
        end
    end

    assign min_l = {1'b0, min_l_q};
    assign min_r = {1'b0, min_r_q};
    assign sec_l = {1'b0, sec_l_q};
    assign sec_r = {1'b0, sec_r_q};

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed self-checking bench for stopwatch_counter; expected displays
// are written as MMSS decimals and expanded into four 5-bit digits.
module tb_stopwatch_counter;

    logic        clk = 1'b0;
    logic        rst;
    logic [26:0] out1;
    logic        paused;
    logic [2:0]  adj_sel;
    logic [4:0]  adj_val;
    logic [4:0]  min_l, min_r, sec_l, sec_r;

    int total = 0;
    int bad   = 0;

    stopwatch_counter dut (
        .clk     (clk),
        .rst     (rst),
        .out1    (out1),
        .paused  (paused),
        .adj_sel (adj_sel),
        .adj_val (adj_val),
        .min_l   (min_l),
        .min_r   (min_r),
        .sec_l   (sec_l),
        .sec_r   (sec_r)
    );

    always #5 clk = ~clk;

    function automatic logic [19:0] mk(input int mmss);
        logic [4:0] d3, d2, d1, d0;
        d3 = 5'((mmss / 1000) % 10);
        d2 = 5'((mmss / 100) % 10);
        d1 = 5'((mmss / 10) % 10);
        d0 = 5'(mmss % 10);
        return {d3, d2, d1, d0};
    endfunction

    task automatic check(input string tag, input int mmss);
        logic [19:0] got, exp;
        got = {min_l, min_r, sec_l, sec_r};
        exp = mk(mmss);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic clocks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic adjust(input logic [2:0] sel, input logic [4:0] val);
        adj_sel = sel;
        adj_val = val;
        clocks(1);
    endtask

    initial begin
        rst = 1'b1; out1 = 27'd0; paused = 1'b0; adj_sel = 3'd0; adj_val = 5'd0;
        clocks(5);
        check("reset_held", 0);
        rst = 1'b0;
        check("reset_release", 0);

        clocks(9);  check("count_9", 9);
        clocks(1);  check("count_10", 10);
        clocks(50); check("count_60", 100);

        out1 = 27'd5;
        clocks(20); check("no_tick_hold", 100);
        out1 = 27'd0;
        clocks(3);  check("tick_resume", 103);

        paused = 1'b1;
        clocks(10); check("paused_frozen", 103);
        adjust(3'd3, 5'd7);  check("adj_sec_l_sat", 153);
        adjust(3'd1, 5'd12); check("adj_min_l_sat", 9153);
        adj_sel = 3'd0; adj_val = 5'd4;
        clocks(2);  check("adj_sel_0", 9153);
        adj_sel = 3'd5;
        clocks(2);  check("adj_sel_5", 9153);
        adj_sel = 3'd4; adj_val = 5'd2;
        clocks(3);  check("adj_hold_idem", 9152);

        paused = 1'b0; out1 = 27'd5; adj_sel = 3'd2; adj_val = 5'd0;
        clocks(2);  check("adj_unpaused_ignored", 9152);
        adj_sel = 3'bxxx;
        clocks(2);  check("adj_x_unpaused", 9152);

        paused = 1'b1;
        adjust(3'd1, 5'd9);
        adjust(3'd2, 5'd9);
        adjust(3'd3, 5'd9);
        adjust(3'd4, 5'd9);
        check("set_99_59", 9959);
        adj_sel = 3'd0; paused = 1'b0; out1 = 27'd0;
        clocks(1);  check("wrap_99_59", 0);

        paused = 1'b1;
        adjust(3'd2, 5'd9);
        adjust(3'd3, 5'd5);
        adjust(3'd4, 5'd9);
        adj_sel = 3'd0; paused = 1'b0;
        clocks(1);  check("carry_09_59", 1000);

        paused = 1'b1;
        adjust(3'd1, 5'd1);
        adjust(3'd2, 5'd2);
        adjust(3'd3, 5'd3);
        adjust(3'd4, 5'd4);
        adj_sel = 3'd0; paused = 1'b0;
        check("set_12_34", 1234);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("async_reset", 0);
        paused = 1'b1; adj_sel = 3'd1; adj_val = 5'd3;
        clocks(2);  check("reset_over_adjust", 0);
        paused = 1'b0; adj_sel = 3'd0;
        rst = 1'b0;

        clocks(5);  check("count_to_05", 5);
        paused = 1'b1;
        adjust(3'd4, 5'd8);  check("adj_sec_r_8", 8);
        adj_sel = 3'd0; paused = 1'b0;
        clocks(1);  check("unpause_first_tick", 9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
